// File: rtl/epu_verify_sched.sv
// Ed25519 verify scheduler: queues tagged jobs, sequences GFNV then GDSV, returns a tagged verdict.
// Optional per-stage watchdog enabled by defining EPU_WDOG_EN.
module epu_verify_sched #(
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 4,
  parameter int WDOG_CYC = 65535
) (
  input  logic                     modclk,
  input  logic                     resetn,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [TAG_W-1:0]         job_tag,
  input  logic [511:0]             job_sig,
  input  logic [255:0]             job_key,
  input  logic [255:0]             job_rhash,
  output logic                     gfnv_valid,
  output logic [255:0]             gfnv_key,
  input  logic                     gfnv_done,
  input  logic                     gfnv_error,
  output logic                     gdsv_valid,
  output logic [255:0]             gdsv_a,
  output logic [255:0]             gdsv_b,
  input  logic                     gdsv_done,
  input  logic [255:0]             gdsv_bytes,
  output logic [1:0]               alu_sel,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [TAG_W-1:0]         res_tag,
  output logic [1:0]               res_code,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_G1_START = 3'd1,
    S_G1_WAIT  = 3'd2,
    S_G2_START = 3'd3,
    S_G2_WAIT  = 3'd4,
    S_RESULT   = 3'd5
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [TAG_W-1:0]  q_tag_r   [DEPTH];
  logic [511:0]      q_sig_r   [DEPTH];
  logic [255:0]      q_key_r   [DEPTH];
  logic [255:0]      q_rhash_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r, count_nxt_s;
  logic              push_s, pop_s;
  logic [TAG_W-1:0]  cur_tag_r;
  logic [255:0]      cur_r_r;
  logic [1:0]        code_r, code_nxt_s;
  logic              res_valid_nxt_s;
  logic              wdog_exp_s;

  assign push_s      = job_valid && job_ready;
  assign count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
  assign occupancy   = count_r;

`ifdef EPU_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);
  logic [WDW-1:0] wdog_cnt_r;

  assign wdog_exp_s = (wdog_cnt_r == WDW'(WDOG_CYC - 1));

  // Stage watchdog: cleared while starting a stage, counts each cycle spent waiting
  always_ff @(posedge modclk or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt_r <= WDW'(0);
    end else if (state_r == S_G1_START || state_r == S_G2_START) begin
      wdog_cnt_r <= WDW'(0);
    end else if ((state_r == S_G1_WAIT || state_r == S_G2_WAIT) && !wdog_exp_s) begin
      wdog_cnt_r <= wdog_cnt_r + WDW'(1);
    end
  end
`else
  logic [31:0] unused_wdog_s;
  assign unused_wdog_s = 32'(WDOG_CYC);
  assign wdog_exp_s    = 1'b0;
`endif

  // Queue storage; data slots need no reset since count_r gates their use
  always_ff @(posedge modclk) begin
    if (push_s) begin
      q_tag_r[wr_ptr_r]   <= job_tag;
      q_sig_r[wr_ptr_r]   <= job_sig;
      q_key_r[wr_ptr_r]   <= job_key;
      q_rhash_r[wr_ptr_r] <= job_rhash;
    end
  end

  // Queue pointers, occupancy and registered ready (full never accepts, even with a same-cycle pop)
  always_ff @(posedge modclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r  <= AW'(0);
      rd_ptr_r  <= AW'(0);
      count_r   <= CW'(0);
      job_ready <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r   <= count_nxt_s;
      job_ready <= (count_nxt_s != CW'(DEPTH));
    end
  end

  // In-flight job fields, held stable until the next pop
  always_ff @(posedge modclk or negedge resetn) begin
    if (!resetn) begin
      cur_tag_r <= TAG_W'(0);
      cur_r_r   <= 256'd0;
      gfnv_key  <= 256'd0;
      gdsv_a    <= 256'd0;
      gdsv_b    <= 256'd0;
    end else if (pop_s) begin
      cur_tag_r <= q_tag_r[rd_ptr_r];
      cur_r_r   <= q_sig_r[rd_ptr_r][255:0];
      gfnv_key  <= q_key_r[rd_ptr_r];
      gdsv_a    <= q_rhash_r[rd_ptr_r];
      gdsv_b    <= q_sig_r[rd_ptr_r][511:256];
    end
  end

  // Next-state, pop and verdict-code decision
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    code_nxt_s  = code_r;
    case (state_r)
      S_IDLE: begin
        if (count_r != CW'(0) && !res_valid) begin
          pop_s       = 1'b1;
          state_nxt_s = S_G1_START;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_G1_START: state_nxt_s = S_G1_WAIT;
      S_G1_WAIT: begin
        if (gfnv_done) begin
          if (gfnv_error) begin
            code_nxt_s  = 2'b10;
            state_nxt_s = S_RESULT;
          end else begin
            state_nxt_s = S_G2_START;
          end
        end else if (wdog_exp_s) begin
          code_nxt_s  = 2'b11;
          state_nxt_s = S_RESULT;
        end else begin
          state_nxt_s = S_G1_WAIT;
        end
      end
      S_G2_START: state_nxt_s = S_G2_WAIT;
      S_G2_WAIT: begin
        if (gdsv_done) begin
          code_nxt_s  = (gdsv_bytes == cur_r_r) ? 2'b00 : 2'b01;
          state_nxt_s = S_RESULT;
        end else if (wdog_exp_s) begin
          code_nxt_s  = 2'b11;
          state_nxt_s = S_RESULT;
        end else begin
          state_nxt_s = S_G2_WAIT;
        end
      end
      S_RESULT: state_nxt_s = S_IDLE;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Verdict valid: set leaving RESULT, cleared after the consumer handshake
  always_comb begin
    res_valid_nxt_s = res_valid;
    if (state_r == S_RESULT) begin
      res_valid_nxt_s = 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid_nxt_s = 1'b0;
    end else begin
      res_valid_nxt_s = res_valid;
    end
  end

  // State register and outputs registered from the next state so they align with it
  always_ff @(posedge modclk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= S_IDLE;
      code_r     <= 2'b00;
      gfnv_valid <= 1'b0;
      gdsv_valid <= 1'b0;
      alu_sel    <= 2'b00;
      res_valid  <= 1'b0;
      res_tag    <= TAG_W'(0);
      res_code   <= 2'b00;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      code_r     <= code_nxt_s;
      gfnv_valid <= (state_nxt_s == S_G1_START);
      gdsv_valid <= (state_nxt_s == S_G2_START);
      case (state_nxt_s)
        S_G1_START, S_G1_WAIT: alu_sel <= 2'b01;
        S_G2_START, S_G2_WAIT: alu_sel <= 2'b10;
        default:               alu_sel <= 2'b00;
      endcase
      res_valid  <= res_valid_nxt_s;
      busy       <= (state_nxt_s != S_IDLE) || res_valid_nxt_s;
      if (state_r == S_RESULT) begin
        res_tag  <= cur_tag_r;
        res_code <= code_r;
      end
    end
  end

endmodule

// File: tb/tb_epu_verify_sched.sv
// Directed self-checking bench for epu_verify_sched; engines are modelled by the stimulus itself.
module tb_epu_verify_sched;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic               modclk = 1'b0;
  logic               resetn;
  logic               job_valid, job_ready;
  logic [TAG_W-1:0]   job_tag;
  logic [511:0]       job_sig;
  logic [255:0]       job_key, job_rhash;
  logic               gfnv_valid, gfnv_done, gfnv_error;
  logic [255:0]       gfnv_key;
  logic               gdsv_valid, gdsv_done;
  logic [255:0]       gdsv_a, gdsv_b, gdsv_bytes;
  logic [1:0]         alu_sel;
  logic               res_valid, res_ready;
  logic [TAG_W-1:0]   res_tag;
  logic [1:0]         res_code;
  logic [$clog2(DEPTH):0] occupancy;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int gfnv_pulses = 0, gdsv_pulses = 0, alu10_cyc = 0, alu11_cyc = 0;

  always #5 modclk = ~modclk;

  epu_verify_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .WDOG_CYC(16)) dut (
    .modclk(modclk), .resetn(resetn),
    .job_valid(job_valid), .job_ready(job_ready), .job_tag(job_tag),
    .job_sig(job_sig), .job_key(job_key), .job_rhash(job_rhash),
    .gfnv_valid(gfnv_valid), .gfnv_key(gfnv_key), .gfnv_done(gfnv_done), .gfnv_error(gfnv_error),
    .gdsv_valid(gdsv_valid), .gdsv_a(gdsv_a), .gdsv_b(gdsv_b),
    .gdsv_done(gdsv_done), .gdsv_bytes(gdsv_bytes),
    .alu_sel(alu_sel), .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_code(res_code), .occupancy(occupancy), .busy(busy)
  );

  always @(posedge modclk) begin
    if (gfnv_valid) gfnv_pulses <= gfnv_pulses + 1;
    if (gdsv_valid) gdsv_pulses <= gdsv_pulses + 1;
    if (alu_sel == 2'b10) alu10_cyc <= alu10_cyc + 1;
    if (alu_sel == 2'b11) alu11_cyc <= alu11_cyc + 1;
  end

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge modclk);
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return gfnv_valid;
      1:       return gdsv_valid;
      2:       return res_valid;
      3:       return alu_sel == 2'b01;
      4:       return alu_sel == 2'b10;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    int n = 0;
    while (!cond(which) && n < 300) begin
      step();
      n++;
    end
    check(name, 256'(cond(which)), 256'd1);
  endtask

  task automatic push(input logic [TAG_W-1:0] tag, input logic [255:0] r, input logic [255:0] s,
                      input logic [255:0] key, input logic [255:0] rh);
    check("push_ready", 256'(job_ready), 256'd1);
    job_valid = 1'b1; job_tag = tag; job_sig = {s, r}; job_key = key; job_rhash = rh;
    step();
    job_valid = 1'b0;
  endtask

  // Hold done inputs until the scheduler moves on; early/stale dones must be ignored
  task automatic complete_job(input logic [255:0] bytes, input logic err);
    wait_for(3, "g1_owns_alu");
    gfnv_done = 1'b1; gfnv_error = err;
    if (err) begin
      wait_for(2, "res_valid_err");
    end else begin
      wait_for(4, "g2_owns_alu");
      gfnv_done = 1'b0;
      gdsv_done = 1'b1; gdsv_bytes = bytes;
      wait_for(2, "res_valid");
    end
    gfnv_done = 1'b0; gfnv_error = 1'b0; gdsv_done = 1'b0;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("ack_clears_valid", 256'(res_valid), 256'd0);
  endtask

  initial begin
    logic [255:0] ra, sa, ka, ha, rc;
    logic [255:0] rq [6];
    int g0, d0, a0;
    logic stable;

    ra = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0001;
    sa = 256'h5a5a_0000_1234_5678;
    ka = 256'hcafe_f00d_0000_0042;
    ha = 256'h0bad_beef_0000_0007;
    rc = 256'h00c0_ffee_0000_0123;

    resetn = 1'b0; job_valid = 1'b0; job_tag = 4'd0; job_sig = 512'd0; job_key = 256'd0;
    job_rhash = 256'd0; gfnv_done = 1'b0; gfnv_error = 1'b0; gdsv_done = 1'b0;
    gdsv_bytes = 256'd0; res_ready = 1'b0;
    step(); step();
    check("rst_job_ready", 256'(job_ready), 256'd1);
    check("rst_res_valid", 256'(res_valid), 256'd0);
    check("rst_occupancy", 256'(occupancy), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_alu_sel", 256'(alu_sel), 256'd0);
    check("rst_gfnv_valid", 256'(gfnv_valid), 256'd0);
    resetn = 1'b1;
    step();

    // Single job, exact timing; stale dones during START cycles are ignored
    g0 = gfnv_pulses; d0 = gdsv_pulses;
    push(4'd3, ra, sa, ka, ha);
    check("t1_occ_after_push", 256'(occupancy), 256'd1);
    check("t1_no_bypass", 256'(gfnv_valid), 256'd0);
    step();
    check("t1_gfnv_valid", 256'(gfnv_valid), 256'd1);
    check("t1_alu_g1", 256'(alu_sel), 256'd1);
    check("t1_gfnv_key", gfnv_key, ka);
    check("t1_occ_popped", 256'(occupancy), 256'd0);
    check("t1_busy", 256'(busy), 256'd1);
    gfnv_done = 1'b1; gfnv_error = 1'b1;
    step();
    check("t1_gfnv_pulse_end", 256'(gfnv_valid), 256'd0);
    check("t1_alu_g1_wait", 256'(alu_sel), 256'd1);
    gfnv_error = 1'b0;
    step();
    gfnv_done = 1'b0;
    check("t1_gdsv_valid", 256'(gdsv_valid), 256'd1);
    check("t1_alu_g2", 256'(alu_sel), 256'd2);
    check("t1_gdsv_a", gdsv_a, ha);
    check("t1_gdsv_b", gdsv_b, sa);
    gdsv_done = 1'b1; gdsv_bytes = ~ra;
    step();
    check("t1_gdsv_pulse_end", 256'(gdsv_valid), 256'd0);
    gdsv_bytes = ra;
    step();
    gdsv_done = 1'b0;
    check("t1_alu_result", 256'(alu_sel), 256'd0);
    check("t1_res_not_yet", 256'(res_valid), 256'd0);
    step();
    check("t1_res_valid", 256'(res_valid), 256'd1);
    check("t1_res_tag", 256'(res_tag), 256'd3);
    check("t1_res_code", 256'(res_code), 256'd0);
    ack();
    check("t1_idle_busy", 256'(busy), 256'd0);
    check("t1_gfnv_pulses", 256'(gfnv_pulses - g0), 256'd1);
    check("t1_gdsv_pulses", 256'(gdsv_pulses - d0), 256'd1);

    // Key decode error: GDSV never started, ALUs never handed to GDSV
    d0 = gdsv_pulses; a0 = alu10_cyc;
    push(4'd5, ra, sa, ka ^ 256'd1, ha);
    complete_job(256'd0, 1'b1);
    check("t2_res_tag", 256'(res_tag), 256'd5);
    check("t2_res_code", 256'(res_code), 256'd2);
    ack();
    check("t2_no_gdsv", 256'(gdsv_pulses - d0), 256'd0);
    check("t2_no_alu10", 256'(alu10_cyc - a0), 256'd0);

    // R mismatch, verdict held 50 cycles with another job queued behind it
    push(4'd9, rc, sa, ka, ha);
    push(4'd10, ra, sa, ka, ha);
    complete_job(rc ^ 256'd1, 1'b0);
    check("t3_res_tag", 256'(res_tag), 256'd9);
    check("t3_res_code", 256'(res_code), 256'd1);
    g0 = gfnv_pulses;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!(res_valid === 1'b1 && res_tag === 4'd9 && res_code === 2'b01)) stable = 1'b0;
    end
    check("t3_hold_stable", 256'(stable), 256'd1);
    check("t3_next_not_popped", 256'(gfnv_pulses - g0), 256'd0);
    check("t3_occ_held", 256'(occupancy), 256'd1);
    ack();
    complete_job(ra, 1'b0);
    check("t3_next_tag", 256'(res_tag), 256'd10);
    check("t3_next_code", 256'(res_code), 256'd0);
    ack();

    // Fill: DEPTH queued plus one in flight with engines stalled, then drain in order
    for (int i = 1; i <= DEPTH + 1; i++) begin
      rq[i] = 256'(i) * 256'h0101_0101_0000_0077;
      job_valid = 1'b1; job_tag = 4'(i); job_sig = {sa, rq[i]}; job_key = ka; job_rhash = ha;
      step();
    end
    check("t4_full_not_ready", 256'(job_ready), 256'd0);
    check("t4_full_occ", 256'(occupancy), 256'd4);
    job_tag = 4'd15;
    step(); step(); step();
    job_valid = 1'b0;
    check("t4_no_push_when_full", 256'(occupancy), 256'd4);
    for (int i = 1; i <= DEPTH + 1; i++) begin
      complete_job(rq[i], 1'b0);
      check("t4_order_tag", 256'(res_tag), 256'(i));
      check("t4_order_code", 256'(res_code), 256'd0);
      ack();
    end
    check("t4_drained_occ", 256'(occupancy), 256'd0);
    check("t4_ready_again", 256'(job_ready), 256'd1);

    // Reset during G2_WAIT with a job still queued; stale done afterwards ignored
    push(4'd7, ra, sa, ka, ha);
    push(4'd8, ra, sa, ka, ha);
    wait_for(3, "t5_g1_owns_alu");
    gfnv_done = 1'b1;
    wait_for(4, "t5_g2_owns_alu");
    gfnv_done = 1'b0;
    step(); step();
    check("t5_in_g2_wait", 256'(alu_sel), 256'd2);
    check("t5_occ_before", 256'(occupancy), 256'd1);
    resetn = 1'b0;
    #1;
    check("t5_rst_alu_sel", 256'(alu_sel), 256'd0);
    check("t5_rst_occ", 256'(occupancy), 256'd0);
    check("t5_rst_ready", 256'(job_ready), 256'd1);
    check("t5_rst_busy", 256'(busy), 256'd0);
    check("t5_rst_gdsv_a", gdsv_a, 256'd0);
    step();
    g0 = gfnv_pulses;
    gdsv_done = 1'b1; gdsv_bytes = ra;
    resetn = 1'b1;
    step(); step(); step();
    gdsv_done = 1'b0;
    check("t5_stale_done_res", 256'(res_valid), 256'd0);
    check("t5_stale_done_busy", 256'(busy), 256'd0);
    check("t5_queue_empty", 256'(gfnv_pulses - g0), 256'd0);

`ifdef EPU_WDOG_EN
    // Watchdog: GFNV never answers, timeout after 16 cycles in G1_WAIT
    d0 = gdsv_pulses;
    push(4'd11, ra, sa, ka, ha);
    wait_for(0, "t6_gfnv_start");
    for (int i = 0; i < 16; i++) step();
    check("t6_still_g1_wait", 256'(alu_sel), 256'd1);
    step();
    check("t6_alu_released", 256'(alu_sel), 256'd0);
    gfnv_done = 1'b1;
    step();
    check("t6_res_valid", 256'(res_valid), 256'd1);
    check("t6_res_tag", 256'(res_tag), 256'd11);
    check("t6_res_code", 256'(res_code), 256'd3);
    step();
    gfnv_done = 1'b0;
    ack();
    check("t6_late_done_ignored", 256'(gdsv_pulses - d0), 256'd0);
    check("t6_idle", 256'(busy), 256'd0);
`endif

    check("never_alu_11", 256'(alu11_cyc), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
